// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing generator on the PLL pixel clock.
// Counting is gated by a 2-flop synchronized PLL lock; all outputs are registered.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam int unsigned HS_BEG = H_VISIBLE + H_FP;
    localparam int unsigned HS_END = H_VISIBLE + H_FP + H_SYNC;
    localparam int unsigned VS_BEG = V_VISIBLE + V_FP;
    localparam int unsigned VS_END = V_VISIBLE + V_FP + V_SYNC;

    logic          r_sync1;
    logic          r_lock_s;
    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;

    logic          r_hsync;
    logic          r_vsync;
    logic          r_video_on;
    logic [9:0]    r_pix_x;
    logic [9:0]    r_pix_y;
    logic          r_line_start;
    logic          r_frame_start;

    logic [31:0]   w_h;
    logic [31:0]   w_v;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_hs_on;
    logic          w_vs_on;
    logic          w_von;

    assign w_h      = 32'(r_hcnt);
    assign w_v      = 32'(r_vcnt);
    assign w_h_last = (w_h == H_TOTAL - 1);
    assign w_v_last = (w_v == V_TOTAL - 1);
    assign w_hs_on  = (w_h >= HS_BEG) && (w_h < HS_END);
    assign w_vs_on  = (w_v >= VS_BEG) && (w_v < VS_END);
    assign w_von    = (w_h < H_VISIBLE) && (w_v < V_VISIBLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= pll_locked;
            r_lock_s <= r_sync1;
        end
    end

    // Losing lock restarts from (0,0); a partial frame is never resumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (!r_lock_s) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_h_last) begin
            r_hcnt <= '0;
            r_vcnt <= w_v_last ? '0 : r_vcnt + VW'(1);
        end else begin
            r_hcnt <= r_hcnt + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hsync       <= ~SYNC_ACTIVE;
            r_vsync       <= ~SYNC_ACTIVE;
            r_video_on    <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (!r_lock_s) begin
            r_hsync       <= ~SYNC_ACTIVE;
            r_vsync       <= ~SYNC_ACTIVE;
            r_video_on    <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_hs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync       <= w_vs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_video_on    <= w_von;
            r_pix_x       <= w_von ? 10'(r_hcnt) : 10'd0;
            r_pix_y       <= w_von ? 10'(r_vcnt) : 10'd0;
            r_line_start  <= (w_h == 0);
            r_frame_start <= (w_h == 0) && (w_v == 0);
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
